// File: rtl/job_supervisor.sv
// job_supervisor: launches one worker job per host start, watches it with a
//   timeout, aborts (kill hold + one recover cycle) and relaunches up to MAX_RETRY.
// Latency: go one cycle after an accepted start; job_ok/job_fail registered, one
//   cycle after the deciding event. Backpressure: none; start is ignored while busy.
// Ports:
//   clk, reset          clock, asynchronous active-high reset
//   start               host request, sampled only in IDLE
//   cancel              host abort level, sampled every busy cycle
//   done_in             worker completion pulse, sampled only in WAIT
//   go                  one-cycle launch strobe to the worker
//   kill                abort level to the worker
//   busy                high in every state except IDLE
//   job_ok, job_fail    one-cycle result pulses on entry to IDLE
//   fail_code[1:0]      00 none, 01 timeout, 10 cancelled (held until next start)
//   attempts[3:0]       relaunch count of the current/last job (held until next start)
module job_supervisor #(
  parameter int TIMEOUT   = 100,
  parameter int KILL_HOLD = 4,
  parameter int MAX_RETRY = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       cancel,
  input  logic       done_in,
  output logic       go,
  output logic       kill,
  output logic       busy,
  output logic       job_ok,
  output logic       job_fail,
  output logic [1:0] fail_code,
  output logic [3:0] attempts
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LAUNCH  = 3'd1,
    S_WAIT    = 3'd2,
    S_ABORT   = 3'd3,
    S_RECOVER = 3'd4
  } state_t;

  localparam logic [15:0] TIMER_LAST = 16'(TIMEOUT - 1);
  localparam logic [7:0]  HOLD_LAST  = 8'(KILL_HOLD - 1);
  localparam logic [3:0]  RETRY_MAX  = 4'(MAX_RETRY);

  localparam logic [1:0] CODE_NONE    = 2'b00;
  localparam logic [1:0] CODE_TIMEOUT = 2'b01;
  localparam logic [1:0] CODE_CANCEL  = 2'b10;

  state_t      state, state_nxt;
  logic [15:0] timer, timer_nxt;
  logic [7:0]  hold_cnt, hold_nxt;
  logic        cancel_flag, cancel_nxt;
  logic [1:0]  fail_code_nxt;
  logic [3:0]  attempts_nxt;
  logic        job_ok_nxt, job_fail_nxt;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= S_IDLE;
      timer       <= '0;
      hold_cnt    <= '0;
      cancel_flag <= 1'b0;
      fail_code   <= CODE_NONE;
      attempts    <= '0;
      job_ok      <= 1'b0;
      job_fail    <= 1'b0;
    end else begin
      state       <= state_nxt;
      timer       <= timer_nxt;
      hold_cnt    <= hold_nxt;
      cancel_flag <= cancel_nxt;
      fail_code   <= fail_code_nxt;
      attempts    <= attempts_nxt;
      job_ok      <= job_ok_nxt;
      job_fail    <= job_fail_nxt;
    end
  end

  always_comb begin
    state_nxt     = state;
    timer_nxt     = timer;
    hold_nxt      = hold_cnt;
    cancel_nxt    = cancel_flag;
    fail_code_nxt = fail_code;
    attempts_nxt  = attempts;
    job_ok_nxt    = 1'b0;
    job_fail_nxt  = 1'b0;

    case (state)
      S_IDLE: begin
        if (start) begin
          state_nxt     = S_LAUNCH;
          attempts_nxt  = '0;
          fail_code_nxt = CODE_NONE;
          cancel_nxt    = 1'b0;
        end
      end

      S_LAUNCH: begin
        timer_nxt = '0;
        hold_nxt  = '0;
        if (cancel) begin
          cancel_nxt = 1'b1;
          state_nxt  = S_ABORT;
        end else begin
          state_nxt = S_WAIT;
        end
      end

      S_WAIT: begin
        // done_in wins over cancel, cancel wins over the timeout.
        if (done_in) begin
          state_nxt  = S_IDLE;
          job_ok_nxt = 1'b1;
        end else if (cancel) begin
          cancel_nxt = 1'b1;
          hold_nxt   = '0;
          state_nxt  = S_ABORT;
        end else if (timer == TIMER_LAST) begin
          hold_nxt  = '0;
          state_nxt = S_ABORT;
        end else begin
          timer_nxt = timer + 16'd1;
        end
      end

      S_ABORT: begin
        // A cancel here only blocks the relaunch; the kill hold runs to completion.
        if (cancel) begin
          cancel_nxt = 1'b1;
        end
        if (hold_cnt == HOLD_LAST) begin
          state_nxt = S_RECOVER;
        end else begin
          hold_nxt = hold_cnt + 8'd1;
        end
      end

      S_RECOVER: begin
        // A cancel arriving in this very cycle still counts for the exit decision.
        if (cancel_flag || cancel) begin
          cancel_nxt    = 1'b1;
          state_nxt     = S_IDLE;
          fail_code_nxt = CODE_CANCEL;
          job_fail_nxt  = 1'b1;
        end else if (attempts >= RETRY_MAX) begin
          state_nxt     = S_IDLE;
          fail_code_nxt = CODE_TIMEOUT;
          job_fail_nxt  = 1'b1;
        end else begin
          attempts_nxt = attempts + 4'd1;
          state_nxt    = S_LAUNCH;
        end
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // Decoded straight from the state register so an asynchronous reset drops
  // go/kill in the same cycle; LAUNCH and ABORT are exclusive so go and kill are too.
  always_comb begin
    go   = (state == S_LAUNCH);
    kill = (state == S_ABORT);
    busy = (state != S_IDLE);
  end

endmodule

// File: doc/job_supervisor.md
JOB_SUPERVISOR -- requirements
Module: job_supervisor

Interface
REQ-001 Parameter TIMEOUT, default 100: WAIT-state cycles allowed before abort; legal range 2..65535.
REQ-002 Parameter KILL_HOLD, default 4: cycles kill is held high per abort; legal range 1..255.
REQ-003 Parameter MAX_RETRY, default 2: relaunches allowed after the first attempt; legal range 0..15.
REQ-004 clk  input  1  clock; all state updates on rising edge.
REQ-005 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-006 start  input  1  host request to run one job; sampled only in IDLE.
REQ-007 cancel  input  1  host abort request; level-sensitive, sampled every cycle while busy.
REQ-008 done_in  input  1  worker completion pulse; sampled only in WAIT.
REQ-009 go  output  1  launch strobe to worker; one-cycle pulse.
REQ-010 kill  output  1  abort level to worker.
REQ-011 busy  output  1  high in every state except IDLE.
REQ-012 job_ok  output  1  one-cycle pulse on successful completion.
REQ-013 job_fail  output  1  one-cycle pulse on final failure.
REQ-014 fail_code  output  2  00 none, 01 timeout, 10 cancelled; held until next accepted start.
REQ-015 attempts  output  4  relaunch count for the current/last job; held until next accepted start.

Function
REQ-016 Five states SHALL exist: IDLE, LAUNCH, WAIT, ABORT, RECOVER; encoding is free, unused codes SHALL return to IDLE.
REQ-017 IDLE: start=1 SHALL move to LAUNCH, clearing attempts, fail_code and the cancel flag; start=0 holds IDLE.
REQ-018 LAUNCH: go=1 for exactly this cycle, timer cleared to 0; next state WAIT unconditionally, except cancel=1 sets the cancel flag and moves to ABORT.
REQ-019 WAIT: 16-bit timer increments each cycle, starting at 0 on WAIT entry.
REQ-020 WAIT priority SHALL be done_in > cancel > timeout.
REQ-021 WAIT with done_in=1 -> IDLE; job_ok=1 on the cycle IDLE is entered; fail_code stays 00.
REQ-022 WAIT with cancel=1 (no done_in) -> ABORT, cancel flag set.
REQ-023 WAIT with timer == TIMEOUT-1 and no done_in/cancel -> ABORT, so WAIT lasts exactly TIMEOUT cycles.
REQ-024 ABORT: kill=1 for exactly KILL_HOLD consecutive cycles (hold counter cleared on entry), then -> RECOVER.
REQ-025 RECOVER: kill=0, go=0 for exactly one cycle, letting the worker return to idle.
REQ-026 RECOVER exit: cancel flag set -> IDLE, fail_code=10, job_fail pulse.
REQ-027 RECOVER exit: attempts == MAX_RETRY -> IDLE, fail_code=01, job_fail pulse.
REQ-028 RECOVER exit otherwise: attempts += 1 -> LAUNCH.
REQ-029 cancel=1 in ABORT or RECOVER SHALL set the cancel flag (no further relaunch) without shortening the kill hold.
REQ-030 start while busy and done_in outside WAIT SHALL be ignored; go and kill SHALL never be high in the same cycle.
REQ-031 job_ok and job_fail SHALL be registered, mutually exclusive, and low in all other cycles.
REQ-032 attempts SHALL never exceed MAX_RETRY; no counter wraps.

Reset
REQ-033 On reset: state IDLE; go, kill, busy, job_ok, job_fail = 0; fail_code = 00; attempts = 0; timer, hold counter, cancel flag = 0.
REQ-034 Reset asserted mid-job (including during ABORT) SHALL drop kill/go within the same cycle and discard the job, with no job_ok/job_fail pulse.

Verification
REQ-035 start at cycle 0, done_in 10 cycles after go -> single go pulse, job_ok pulse, fail_code=00, attempts=0, busy low afterwards.
REQ-036 TIMEOUT=100, done_in never asserted -> 3 go pulses, each followed 100 cycles later by 4 kill cycles; job_fail, fail_code=01, attempts=2.
REQ-037 cancel asserted 5 cycles into WAIT -> kill for 4 cycles, 1 RECOVER cycle, job_fail, fail_code=10, no relaunch.
REQ-038 done_in and timeout on the same cycle (timer=99) -> job_ok, no kill.
REQ-039 First attempt times out, done_in on the second attempt -> job_ok, attempts=1, fail_code=00.
REQ-040 reset pulsed during ABORT cycle 2 -> kill=0 immediately, all outputs at reset values; start is accepted on the first cycle after reset release.
